// File: rtl/keypad_scan.sv
// keypad_scan: sync, debounce and chord rejection for a 10-key pad.
// Emits one key_valid strobe with key_code per accepted press.
module keypad_scan #(
  parameter int DEBOUNCE_CYC = 20,
  parameter int RELEASE_CYC  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] keypad,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_pressed,
  output logic       key_multi
);

  localparam int CMAX =
    (DEBOUNCE_CYC > RELEASE_CYC) ? DEBOUNCE_CYC : RELEASE_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] RL_LAST = CW'(RELEASE_CYC - 1);
  localparam logic [CW-1:0] C_MAX   = CW'(CMAX);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEB,
    S_PRESSED,
    S_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    cand_q, cand_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_pressed_q, key_pressed_d;
  logic          key_multi_q;

  logic [3:0]    nlow;
  logic [3:0]    idx;
  logic          is_none, is_single, is_multi, match;

  // Two-flop synchroniser on the asynchronous key lines
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= keypad;
      s2_q <= s1_q;
    end
  end

  // Classify the synchronised pattern: none, single key n, or chord
  always_comb begin
    nlow = '0;
    idx  = '0;
    for (int i = 0; i < 10; i++) begin
      if (!s2_q[i]) begin
        nlow = nlow + 4'd1;
        idx  = 4'(i);
      end
    end
    is_none   = (nlow == 4'd0);
    is_single = (nlow == 4'd1);
    is_multi  = (nlow > 4'd1);
    match     = is_single && (idx == cand_q);
    cnt_inc   = (cnt_q == C_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_RELEASE;
      cnt_q         <= '0;
      cand_q        <= '0;
      key_valid_q   <= 1'b0;
      key_code_q    <= '0;
      key_pressed_q <= 1'b0;
      key_multi_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cand_q        <= cand_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      key_pressed_q <= key_pressed_d;
      key_multi_q   <= is_multi;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (is_single) state_d = S_DEB;
      end
      S_DEB: begin
        if (!match)               state_d = S_IDLE;
        else if (cnt_q == DB_LAST) state_d = S_PRESSED;
      end
      S_PRESSED: begin
        if (is_none) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!is_none)              state_d = S_PRESSED;
        else if (cnt_q == RL_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter, candidate and strobe generation
  always_comb begin
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    unique case (state_q)
      S_IDLE: begin
        if (is_single) begin
          cand_d = idx;
          cnt_d  = C_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      S_DEB: begin
        if (!match) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          key_valid_d = 1'b1;
          key_code_d  = cand_q;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_PRESSED: begin
        cnt_d = is_none ? C_ONE : '0;
      end
      S_RELEASE: begin
        if (!is_none || cnt_q == RL_LAST) cnt_d = '0;
        else                              cnt_d = cnt_inc;
      end
      default: cnt_d = '0;
    endcase
    key_pressed_d = (state_d == S_PRESSED) ||
                    (state_d == S_RELEASE);
  end

  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_pressed = key_pressed_q;
  assign key_multi   = key_multi_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed presses checked against a run-length model.
// Model compared every cycle; literal latencies pin the model.
module tb_keypad_scan;

  localparam int DB = 20;
  localparam int RC = 20;

  logic       clk;
  logic       rst;
  logic [9:0] keypad;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_pressed;
  logic       key_multi;

  keypad_scan #(
    .DEBOUNCE_CYC(DB),
    .RELEASE_CYC (RC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .keypad     (keypad),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_pressed(key_pressed),
    .key_multi  (key_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Behavioural model: run lengths of identical single-key samples
  // and of all-released samples, behind a 2-sample sync delay.
  int         cyc = 0;
  logic [9:0] m_s1 = 10'h3FF;
  logic [9:0] m_s2 = 10'h3FF;
  bit         held = 1'b1;
  int         nrun = 0;
  int         run = 0;
  int         cand = 0;
  bit         m_valid = 1'b0;
  int         m_code = 0;
  bit         m_pressed = 1'b0;
  bit         m_multi = 1'b0;

  always @(posedge clk) begin
    int nl;
    int ix;
    cyc++;
    if (!rst) begin
      m_s1 = 10'h3FF;
      m_s2 = 10'h3FF;
      held = 1'b1;
      nrun = 0;
      run = 0;
      m_valid = 1'b0;
      m_code = 0;
      m_pressed = 1'b0;
      m_multi = 1'b0;
    end else begin
      nl = 0;
      ix = 0;
      for (int i = 0; i < 10; i++)
        if (!m_s2[i]) begin nl++; ix = i; end
      m_valid = 1'b0;
      if (held) begin
        if (nl == 0) begin
          nrun++;
          if (nrun == RC) begin held = 1'b0; run = 0; end
        end else begin
          nrun = 0;
        end
      end else if (nl == 1) begin
        if (run > 0 && ix == cand) begin
          run++;
          if (run == DB) begin
            m_valid = 1'b1;
            m_code = cand;
            held = 1'b1;
            nrun = 0;
            run = 0;
          end
        end else if (run > 0) begin
          run = 0;
        end else begin
          cand = ix;
          run = 1;
        end
      end else begin
        run = 0;
      end
      m_pressed = held;
      m_multi = (nl > 1);
      m_s2 = m_s1;
      m_s1 = keypad;
    end
  end

  // Per-cycle comparison plus strobe bookkeeping for literal checks
  int   nstrobe = 0;
  int   strobe_cyc = 0;
  int   last_code = 0;
  int   fall_cyc = 0;
  int   wide = 0;
  bit   prev_valid = 1'b0;
  bit   prev_pressed = 1'b0;
  int   codes[$];

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("key_valid", int'(key_valid), int'(m_valid));
      check("key_code", int'(key_code), m_code);
      check("key_pressed", int'(key_pressed), int'(m_pressed));
      check("key_multi", int'(key_multi), int'(m_multi));
      if (key_valid === 1'b1) begin
        nstrobe++;
        strobe_cyc = cyc;
        last_code = int'(key_code);
        codes.push_back(int'(key_code));
        if (prev_valid) wide++;
      end
      if (prev_pressed && key_pressed === 1'b0) fall_cyc = cyc;
      prev_valid = (key_valid === 1'b1);
      prev_pressed = (key_pressed === 1'b1);
    end
  end

  function automatic logic [9:0] kmask(input int n);
    logic [9:0] one;
    one = 10'd1;
    return 10'h3FF & ~(one << n);
  endfunction

  task automatic set_keys(input logic [9:0] v);
    @(posedge clk);
    #2 keypad = v;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  int t0;
  int r0;
  int s0;
  int seq[6] = '{2, 3, 5, 9, 4, 1};

  initial begin
    rst = 1'b0;
    keypad = 10'h3FF;
    @(posedge clk);
    @(negedge clk);
    check("reset key_code", int'(key_code), 0);
    check("reset key_pressed", int'(key_pressed), 0);
    check("reset key_valid", int'(key_valid), 0);
    wait_cyc(2);
    #2 rst = 1'b1;
    wait_cyc(25);

    // Clean press of key 7
    s0 = nstrobe;
    set_keys(kmask(7));
    t0 = cyc;
    wait_cyc(100);
    set_keys(10'h3FF);
    r0 = cyc;
    wait_cyc(40);
    check("k7 strobes", nstrobe - s0, 1);
    check("k7 code", last_code, 7);
    check("k7 latency", strobe_cyc - t0, 22);
    check("k7 release", fall_cyc - r0, 22);

    // Bouncing key 3
    s0 = nstrobe;
    set_keys(kmask(3));
    t0 = cyc;
    wait_cyc(4);
    set_keys(10'h3FF);
    set_keys(kmask(3));
    wait_cyc(40);
    set_keys(10'h3FF);
    wait_cyc(40);
    check("k3 strobes", nstrobe - s0, 1);
    check("k3 code", last_code, 3);
    check("k3 latency", strobe_cyc - t0, 28);

    // Chord 2+5
    s0 = nstrobe;
    set_keys(kmask(2) & kmask(5));
    wait_cyc(50);
    @(negedge clk);
    check("chord multi", int'(key_multi), 1);
    set_keys(10'h3FF);
    wait_cyc(40);
    @(negedge clk);
    check("chord strobes", nstrobe - s0, 0);
    check("chord code", int'(key_code), 3);
    check("chord multi off", int'(key_multi), 0);

    // Key 4 accepted, key 9 added while held
    s0 = nstrobe;
    set_keys(kmask(4));
    wait_cyc(40);
    set_keys(kmask(4) & kmask(9));
    wait_cyc(20);
    set_keys(10'h3FF);
    wait_cyc(40);
    check("k4 strobes", nstrobe - s0, 1);
    check("k4 code", last_code, 4);

    // Key 1 held across a reset pulse mid-debounce
    s0 = nstrobe;
    set_keys(kmask(1));
    wait_cyc(5);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    wait_cyc(40);
    @(negedge clk);
    check("k1 held strobes", nstrobe - s0, 0);
    check("k1 held code", int'(key_code), 0);
    check("k1 held pressed", int'(key_pressed), 1);
    set_keys(10'h3FF);
    wait_cyc(30);
    s0 = nstrobe;
    set_keys(kmask(1));
    wait_cyc(40);
    set_keys(10'h3FF);
    wait_cyc(40);
    check("k1 strobes", nstrobe - s0, 1);
    check("k1 code", last_code, 1);

    // Six sequential presses
    s0 = nstrobe;
    foreach (seq[i]) begin
      set_keys(kmask(seq[i]));
      wait_cyc(25);
      set_keys(10'h3FF);
      wait_cyc(30);
    end
    check("seq strobes", nstrobe - s0, 6);
    for (int i = 0; i < 6; i++)
      if (s0 + i < codes.size())
        check("seq code", codes[s0 + i], seq[i]);
      else
        check("seq code missing", -1, seq[i]);
    check("strobe width", wide, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Front-end stage for the clock/watch digit-entry path. Takes the 10 raw, active-low keypad lines (idle = all ones), synchronises and debounces them, rejects multi-key chords, and emits exactly one single-cycle `key_valid` strobe with a binary `key_code` (0–9) per physical press. The downstream time-setting logic consumes `key_valid`/`key_code` directly, so one press always loads exactly one digit, regardless of hold time or contact bounce.

## Interface
- `DEBOUNCE_CYC`, default 20: consecutive stable samples needed to accept a press (≥2; at 1 kHz, 20 ms).
- `RELEASE_CYC`, default 20: consecutive all-released samples needed to re-arm (≥2).
- `clk` input 1: 1 kHz system clock; all logic on rising edge.
- `rst` input 1: synchronous, active-low reset.
- `keypad` input 10: raw key lines, bit n low = key n pressed; asynchronous to `clk`.
- `key_valid` output 1: one-cycle strobe, new accepted digit on `key_code`.
- `key_code` output 4: accepted digit 0–9; holds last accepted value between strobes.
- `key_pressed` output 1: high while an accepted key is held or in release debounce.
- `key_multi` output 1: high while the synchronised pattern has more than one key low.

## Operation
- Input sync: 2-stage flop chain per bit (`s1`, `s2`); FSM sees only `s2`. Reset value of both stages 10'h3FF.
- Pattern classes on `s2`: NONE (all ones), SINGLE(n) (exactly bit n low), MULTI (≥2 low).
- States: IDLE, DEBOUNCE, PRESSED, RELEASE. Counter `cnt` sized to max(DEBOUNCE_CYC, RELEASE_CYC); saturates, never wraps.
- IDLE: SINGLE(n) → latch `cand`=n, `cnt`=1, go DEBOUNCE. NONE/MULTI → stay.
- DEBOUNCE: SINGLE(cand) and `cnt`==DEBOUNCE_CYC−1 → `key_valid`=1, `key_code`=cand, go PRESSED. SINGLE(cand) otherwise → `cnt`+1. Any other pattern (bounce, different key, MULTI, NONE) → IDLE, `cnt`=0, no strobe.
- PRESSED: NONE → `cnt`=1, go RELEASE. Any non-NONE pattern (including extra or different keys) ignored; no second strobe.
- RELEASE: NONE and `cnt`==RELEASE_CYC−1 → IDLE. NONE otherwise → `cnt`+1. Any key low → PRESSED, `cnt`=0.
- `key_pressed` = state ∈ {PRESSED, RELEASE}, registered.
- `key_multi` = registered MULTI flag, independent of state; informational only.
- Codes outside 0–9 cannot be produced.

## Timing
- Reset (rst=0 at an edge): state → RELEASE, `cnt`=0, `s1`/`s2`=3FF, `key_valid`=0, `key_code`=0, `key_pressed`=0, `key_multi`=0. Starting in RELEASE forces RELEASE_CYC idle samples before any press is accepted; a key held through reset release produces no strobe until released and re-pressed.
- Press latency: raw key first sampled low at edge 0 and held clean → FSM enters DEBOUNCE at edge 2, `key_valid` high for the single cycle following edge DEBOUNCE_CYC+1 (default: edge 21).
- Any bounce inside DEBOUNCE restarts qualification from the next SINGLE sample; latency counts from the last clean sample.
- Minimum press-to-press spacing: press accepted, release sampled at edge r → earliest re-arm to IDLE at edge r+RELEASE_CYC+1.
- `key_code` updates on the same edge `key_valid` rises; stable thereafter.
- Reset asserted mid-DEBOUNCE: no strobe is ever emitted for that press.

## Test plan
- Clean press of key 7 held 100 cycles, then released → exactly one `key_valid` at edge 21, `key_code`=7, `key_pressed` high until 20 cycles after release is seen.
- Key 3 bouncing (low 5 cycles, high 1, low 40) → single strobe 20 cycles after last bounce, `key_code`=3; no early strobe.
- Keys 2 and 5 low together for 50 cycles → `key_multi`=1 from edge 2, no `key_valid`, `key_code` unchanged.
- Key 4 accepted, key 9 added while held, both released → one strobe (`key_code`=4) only.
- Key 1 held across reset pulse → no strobe after reset; release ≥20 cycles, press key 1 → one strobe, `key_code`=1.
- Six sequential presses 2,3,5,9,4,1 with 30-cycle gaps → six strobes, codes in order, `key_valid` never wider than one cycle.
